// File: rtl/uart_rx_top.sv
// UART receiver: oversampled start detection, 3-sample majority vote per bit, optional parity, stop check.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles on every latency).
module uart_rx_top #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       stop_error,
  output logic       busy
);

  localparam int M    = OVERSAMPLE / 2;
  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam logic [TC_W-1:0] TC_S0   = TC_W'(M - 1);
  localparam logic [TC_W-1:0] TC_S1   = TC_W'(M);
  localparam logic [TC_W-1:0] TC_DEC  = TC_W'(M + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [TC_W-1:0] tc_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            s0_q, s1_q;
  logic            par_en_q, par_type_q, par_err_q;
  logic            rx_s;
  logic            at_dec, at_wrap, vote;
  logic            valid_d, perr_d, serr_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_bit(input logic [7:0] byte_v, input logic even);
    return even ? ^byte_v : ~^byte_v;
  endfunction

`ifdef UART_RX_SYNC_EN
  logic rx_p0, rx_p1;

  // synchronizer stages; idle-high reset so no false start after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;
`else
  assign rx_s = rx_in;
`endif

  assign at_dec  = (tc_q == TC_DEC);
  assign at_wrap = (tc_q == TC_LAST);
  assign vote    = maj3(s0_q, s1_q, rx_s);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    serr_d  = 1'b0;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START: begin
        if (at_dec && vote) state_d = IDLE;
        else if (at_wrap)   state_d = DATA;
      end
      DATA:   if (at_wrap && bit_idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (at_wrap) state_d = STOP;
      STOP: begin
        // leave at the decision tick, not the wrap, so a following start bit is not missed
        if (at_dec) begin
          state_d = IDLE;
          if (!vote)          serr_d  = 1'b1;
          else if (par_err_q) perr_d  = 1'b1;
          else                valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q         <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_err_q    <= 1'b0;
      data         <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= valid_d;
      parity_error <= perr_d;
      stop_error   <= serr_d;
      if (valid_d) data <= shift_q;

      if (state_q == IDLE || state_d == IDLE || at_wrap) tc_q <= '0;
      else                                               tc_q <= tc_q + TC_W'(1);

      if (tc_q == TC_S0) s0_q <= rx_s;
      if (tc_q == TC_S1) s1_q <= rx_s;

      // frame format is captured once at the start edge and held for the whole frame
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            par_en_q   <= parity_en;
            par_type_q <= parity_type;
            par_err_q  <= 1'b0;
            bit_idx_q  <= '0;
          end
        end
        DATA: begin
          if (at_dec)  shift_q   <= {vote, shift_q[7:1]};
          if (at_wrap) bit_idx_q <= bit_idx_q + 3'd1;
        end
        PARITY: if (at_dec) par_err_q <= (vote != parity_bit(shift_q, par_type_q));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: directed and random frames checked against a frame-level model
// that predicts outcome, byte and pulse cycle from the line bits alone.
module tb_uart_rx_top;
  localparam int OS = 8;
  localparam int M  = OS / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, rx_in, parity_en, parity_type;
  logic [7:0] data;
  logic       data_valid, parity_error, stop_error, busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         ev_cyc[$];
  int         ev_kind[$];
  int         ev_ones[$];
  logic [7:0] ev_data[$];
  int         exp_cyc[$];
  int         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] model_data;

  uart_rx_top #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .parity_en(parity_en), .parity_type(parity_type),
    .data(data), .data_valid(data_valid), .parity_error(parity_error),
    .stop_error(stop_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every pulse with the index of the edge that produced it (1=valid, 2=parity, 3=stop)
  always @(negedge clk) begin
    if (data_valid || parity_error || stop_error) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back(data_valid ? 1 : (parity_error ? 2 : 3));
      ev_ones.push_back(int'(data_valid) + int'(parity_error) + int'(stop_error));
      ev_data.push_back(data);
    end
  end

  // drive one frame starting at the current negedge and queue the predicted outcome
  task automatic send_frame(input logic [7:0] b, input logic pen, input logic ptype,
                            input logic pbit, input logic stopb);
    int  e, n, ones;
    logic par_ok;
    e = cyc + 1;
    parity_en = pen;
    parity_type = ptype;
    rx_in = 1'b0;
    repeat (OS) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: busy=%b required 1", busy);
    end
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (OS) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (OS) @(negedge clk);
    end
    rx_in = stopb;
    repeat (OS) @(negedge clk);
    rx_in = 1'b1;

    n = pen ? 11 : 10;
    ones = $countones(b) + int'(pbit);
    par_ok = ptype ? (ones % 2 == 0) : (ones % 2 == 1);
    exp_cyc.push_back(e + (n - 1) * OS + M + 2 + SYNC_LAT);
    if (!stopb) begin
      exp_kind.push_back(3);
      exp_data.push_back(model_data);
    end else if (pen && !par_ok) begin
      exp_kind.push_back(2);
      exp_data.push_back(model_data);
    end else begin
      model_data = b;
      exp_kind.push_back(1);
      exp_data.push_back(b);
    end
  endtask

  task automatic check_events(input string name);
    int n;
    repeat (20) @(negedge clk);
    checks++;
    if (ev_cyc.size() != exp_cyc.size()) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d required %0d", name, ev_cyc.size(), exp_cyc.size());
    end
    n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      checks += 4;
      if (ev_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL %s pulse%0d_cycle: got %0d required %0d", name, i, ev_cyc[i], exp_cyc[i]);
      end
      if (ev_kind[i] != exp_kind[i]) begin
        errors++;
        $display("FAIL %s pulse%0d_kind: got %0d required %0d", name, i, ev_kind[i], exp_kind[i]);
      end
      if (ev_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s pulse%0d_data: got %h required %h", name, i, ev_data[i], exp_data[i]);
      end
      if (ev_ones[i] != 1) begin
        errors++;
        $display("FAIL %s pulse%0d_onehot: got %0d pulses high required 1", name, i, ev_ones[i]);
      end
    end
    checks += 2;
    if (data !== model_data) begin
      errors++;
      $display("FAIL %s data_hold: got %h required %h", name, data, model_data);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_idle: got %b required 0", name, busy);
    end
    ev_cyc.delete(); ev_kind.delete(); ev_ones.delete(); ev_data.delete();
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({data, data_valid, parity_error, stop_error, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b se=%b busy=%b required all 0",
               data, data_valid, parity_error, stop_error, busy);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h7D, 1'b1, 1'b0, 1'b1, 1'b1);
    check_events("basic_parity");
  endtask

  task automatic test_no_parity();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_events("no_parity");
  endtask

  task automatic test_parity_error();
    send_frame(8'h7D, 1'b1, 1'b1, 1'b1, 1'b1);
    check_events("parity_error");
  endtask

  task automatic test_framing_and_glitch();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    check_events("stop_error");
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check_events("glitch");
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    check_events("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    rx_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'($urandom);
      repeat (OS) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data, data_valid, parity_error, stop_error, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_frame: got data=%h v=%b pe=%b se=%b busy=%b required all 0",
               data, data_valid, parity_error, stop_error, busy);
    end
    rst = 1'b0;
    rx_in = 1'b1;
    model_data = 8'h00;
    repeat (100) @(negedge clk);
    check_events("after_reset");
  endtask

  task automatic test_random();
    logic bad_prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic pen, ptype, pbit, stopb;
      int gap;
      b     = 8'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      pbit  = 1'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      // a low stop bit re-arms start detection; give the line time to settle high again
      gap = $urandom_range(0, 3) + (bad_prev ? 12 : 0);
      rx_in = 1'b1;
      repeat (gap) @(negedge clk);
      send_frame(b, pen, ptype, pbit, stopb);
      bad_prev = !stopb;
    end
    check_events("random");
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    parity_en = 1'b0;
    parity_type = 1'b0;
    model_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_basic();
    test_no_parity();
    test_parity_error();
    test_framing_and_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
